// File: rtl/fp_div_if.sv
// Start/busy/done handshake bundle for the fixed-point divider.
interface fp_div_if #(
   parameter int AW = 14,
   parameter int BW = 14,
   parameter int OW = 18
) ();
   logic          start;
   logic [AW-1:0] a;
   logic [BW-1:0] b;
   logic          busy;
   logic          done;
   logic [OW-1:0] quotient;
   logic          div_by_zero;
   logic          overflow;

   modport master (
      output start, a, b,
      input  busy, done, quotient, div_by_zero, overflow
   );

   modport slave (
      input  start, a, b,
      output busy, done, quotient, div_by_zero, overflow
   );
endinterface

// File: rtl/fp_div.sv
// Signed fixed-point divider: radix-2 restoring division on magnitudes, one
// quotient bit per clock, followed by sign application and saturation.
//
// state  | meaning
// S_IDLE | waiting for start; captures operands
// S_DIV  | one restoring-division step per cycle, NW cycles
// S_FIN  | sign/saturate, register results, pulse done
module fp_div #(
   parameter int int1     = 6,
   parameter int frac1    = 8,
   parameter int int2     = 6,
   parameter int frac2    = 8,
   parameter int out_int  = 6,
   parameter int out_frac = 12
) (
   input  logic     clk,
   input  logic     reset,
   fp_div_if.slave  bus
);
   localparam int SH = out_frac + frac2 - frac1;
   localparam int AW = int1 + frac1;
   localparam int BW = int2 + frac2;
   localparam int NW = AW + SH;
   localparam int OW = out_int + out_frac;
   localparam int CW = $clog2(NW + 1);
   localparam int MW = ((NW > OW) ? NW : OW) + 1;

   localparam logic [MW-1:0] MAX_POS_MAG = {{(MW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic [MW-1:0] MAX_NEG_MAG = MAX_POS_MAG + 1'b1;
   localparam logic [OW-1:0] Q_MAX       = {1'b0, {(OW-1){1'b1}}};
   localparam logic [OW-1:0] Q_MIN       = {1'b1, {(OW-1){1'b0}}};

   if (SH < 0) begin : g_bad_format
      $error("fp_div: out_frac + frac2 must be >= frac1");
   end

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIN} state_t;

   state_t        state_q, state_d;
   logic [NW-1:0] n_q, n_d;
   logic [NW-1:0] q_q, q_d;
   logic [BW-1:0] rem_q, rem_d;
   logic [BW-1:0] bmag_q, bmag_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          neg_q, neg_d;
   logic          dz_q, dz_d;
   logic          az_q, az_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [OW-1:0] quot_q, quot_d;
   logic          dzo_q, dzo_d;
   logic          ovf_q, ovf_d;

   logic [AW-1:0] a_mag;
   logic [BW-1:0] b_mag;
   logic [BW:0]   rem_sh;
   logic [MW-1:0] q_ext;

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      q_d     = q_q;
      rem_d   = rem_q;
      bmag_d  = bmag_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      dz_d    = dz_q;
      az_d    = az_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      quot_d  = quot_q;
      dzo_d   = dzo_q;
      ovf_d   = ovf_q;

      // Magnitudes keep the full operand width so the most-negative value is exact.
      a_mag  = bus.a[AW-1] ? (~bus.a + 1'b1) : bus.a;
      b_mag  = bus.b[BW-1] ? (~bus.b + 1'b1) : bus.b;
      rem_sh = {rem_q, n_q[NW-1]};
      q_ext  = MW'(q_q);

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               neg_d   = bus.a[AW-1] ^ bus.b[BW-1];
               bmag_d  = b_mag;
               n_d     = NW'(a_mag) << SH;
               q_d     = '0;
               rem_d   = '0;
               cnt_d   = CW'(NW);
               az_d    = (bus.a == '0);
               dz_d    = (bus.b == '0);
               busy_d  = 1'b1;
               state_d = (bus.b == '0) ? S_FIN : S_DIV;
            end
         end
         S_DIV: begin
            if (rem_sh >= {1'b0, bmag_q}) begin
               rem_d = BW'(rem_sh - {1'b0, bmag_q});
               q_d   = {q_q[NW-2:0], 1'b1};
            end else begin
               rem_d = rem_sh[BW-1:0];
               q_d   = {q_q[NW-2:0], 1'b0};
            end
            n_d   = n_q << 1;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = S_FIN;
         end
         S_FIN: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
            if (dz_q) begin
               dzo_d  = 1'b1;
               ovf_d  = 1'b0;
               quot_d = az_q ? '0 : (neg_q ? Q_MIN : Q_MAX);
            end else begin
               dzo_d = 1'b0;
               if (!neg_q) begin
                  ovf_d  = (q_ext > MAX_POS_MAG);
                  quot_d = (q_ext > MAX_POS_MAG) ? Q_MAX : q_ext[OW-1:0];
               end else begin
                  ovf_d  = (q_ext > MAX_NEG_MAG);
                  quot_d = (q_ext > MAX_NEG_MAG) ? Q_MIN : (~q_ext[OW-1:0] + 1'b1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         q_q     <= '0;
         rem_q   <= '0;
         bmag_q  <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         dz_q    <= 1'b0;
         az_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quot_q  <= '0;
         dzo_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         q_q     <= q_d;
         rem_q   <= rem_d;
         bmag_q  <= bmag_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         dz_q    <= dz_d;
         az_q    <= az_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         quot_q  <= quot_d;
         dzo_q   <= dzo_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quot_q;
   assign bus.div_by_zero = dzo_q;
   assign bus.overflow    = ovf_q;
endmodule
